// File: rtl/clk_div_checker.sv
// -----------------------------------------------------------------------------
// clk_div_checker
//
// Monitors the divided-clock waveform produced by clk_div. The divided signal
// is sampled in the fast clk domain. For every period the block measures the
// length and the high time in clk cycles and compares them with the expected
// PERIOD / DUTY_TIME. From these results it reports lock, a sticky error, a
// saturating error count and the most recent measurement. Logic that uses the
// divided clock is held off until locked is asserted.
//
// Parameters
//   PERIOD      expected divided period in clk cycles (>= 2)
//   DUTY_TIME   expected high time per period in clk cycles (1 .. PERIOD-1)
//   CNT_W       measurement counter width; 2*PERIOD must be < 2**CNT_W
//   LOCK_COUNT  consecutive good periods required before locked (>= 1)
//
// Ports
//   clk          in   1      fast clock (also the clk_div source clock)
//   reset        in   1      asynchronous, active-low reset
//   div_in       in   1      divided waveform, already synchronous to clk
//   clear        in   1      synchronous clear, same end state as reset
//   meas_period  out  CNT_W  last measured period, clk cycles
//   meas_high    out  CNT_W  last measured high time, clk cycles
//   meas_valid   out  1      one-cycle pulse when meas_period/meas_high update
//   locked       out  1      LOCK_COUNT consecutive good periods, none bad since
//   err          out  1      sticky: any bad period or timeout since reset/clear
//   err_count    out  8      bad periods + timeouts, saturates at 255
// -----------------------------------------------------------------------------
module clk_div_checker #(
  parameter int PERIOD     = 5,
  parameter int DUTY_TIME  = 1,
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             clear,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count
);

  // Counter for consecutive good periods; must be able to hold LOCK_COUNT.
  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  PERIOD_C    = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0]  DUTY_C      = CNT_W'(DUTY_TIME);
  localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(2 * PERIOD);
  localparam logic [CNT_W-1:0]  CNT_ONE_C   = CNT_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_LAST_C = LOCK_W'(LOCK_COUNT - 1);
  localparam logic [LOCK_W-1:0] LOCK_ONE_C  = LOCK_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // waiting for the first rising edge
    ST_MEASURE = 2'd1,  // measuring, collecting a run of good periods
    ST_LOCKED  = 2'd2   // run complete, divided clock considered stable
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,       state_d;
  logic               div_q,         div_d;
  logic [CNT_W-1:0]   period_cnt_q,  period_cnt_d;
  logic [CNT_W-1:0]   high_cnt_q,    high_cnt_d;
  logic [CNT_W-1:0]   meas_period_q, meas_period_d;
  logic [CNT_W-1:0]   meas_high_q,   meas_high_d;
  logic               meas_valid_q,  meas_valid_d;
  logic [LOCK_W-1:0]  good_run_q,    good_run_d;
  logic               err_q,         err_d;
  logic [7:0]         err_count_q,   err_count_d;

  // ---------------------------------------------------------------------------
  // Edge detect and period classification
  // ---------------------------------------------------------------------------
  // div_in is produced in the clk domain, so a one-register delay is enough to
  // find the rising edge; no synchronizer is needed.
  logic rise;
  logic good;
  logic timeout;

  assign rise    = div_in & ~div_q;
  // Evaluated against the counts accumulated over the period that this rising
  // edge terminates.
  assign good    = (period_cnt_q == PERIOD_C) && (high_cnt_q == DUTY_C);
  // A rising edge in the same cycle wins over the timeout.
  assign timeout = (period_cnt_q == TIMEOUT_C) && !rise;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic bad_event;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    div_d         = div_in;
    meas_period_d = meas_period_q;
    meas_high_d   = meas_high_q;
    meas_valid_d  = 1'b0;
    good_run_d    = good_run_q;
    err_d         = err_q;
    err_count_d   = err_count_q;
    bad_event     = 1'b0;

    // Free-running measurement counters: restart on every rising edge,
    // otherwise count up and hold at all-ones so a dead input cannot wrap
    // into a plausible value.
    if (rise) begin
      period_cnt_d = CNT_ONE_C;
    end else if (period_cnt_q != '1) begin
      period_cnt_d = period_cnt_q + CNT_ONE_C;
    end else begin
      period_cnt_d = period_cnt_q;
    end

    if (rise) begin
      high_cnt_d = CNT_ONE_C;
    end else if (div_in && (high_cnt_q != '1)) begin
      high_cnt_d = high_cnt_q + CNT_ONE_C;
    end else begin
      high_cnt_d = high_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        // The first edge only marks a period start; nothing to measure yet.
        if (rise) begin
          state_d    = ST_MEASURE;
          good_run_d = '0;
        end
      end

      ST_MEASURE: begin
        if (rise) begin
          meas_period_d = period_cnt_q;
          meas_high_d   = high_cnt_q;
          meas_valid_d  = 1'b1;
          if (good) begin
            good_run_d = good_run_q + LOCK_ONE_C;
            if (good_run_q == LOCK_LAST_C) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_run_d = '0;
            bad_event  = 1'b1;
          end
        end else if (timeout) begin
          state_d    = ST_IDLE;
          good_run_d = '0;
          bad_event  = 1'b1;
        end
      end

      ST_LOCKED: begin
        if (rise) begin
          meas_period_d = period_cnt_q;
          meas_high_d   = high_cnt_q;
          meas_valid_d  = 1'b1;
          if (!good) begin
            state_d    = ST_MEASURE;
            good_run_d = '0;
            bad_event  = 1'b1;
          end
        end else if (timeout) begin
          state_d    = ST_IDLE;
          good_run_d = '0;
          bad_event  = 1'b1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        good_run_d = '0;
      end
    endcase

    if (bad_event) begin
      err_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end

    // Synchronous clear has the final word over anything decided above,
    // including a rise or timeout in the same cycle.
    if (clear) begin
      state_d       = ST_IDLE;
      div_d         = 1'b0;
      period_cnt_d  = '0;
      high_cnt_d    = '0;
      meas_period_d = '0;
      meas_high_d   = '0;
      meas_valid_d  = 1'b0;
      good_run_d    = '0;
      err_d         = 1'b0;
      err_count_d   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      div_q         <= 1'b0;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      meas_valid_q  <= 1'b0;
      good_run_q    <= '0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      meas_period_q <= meas_period_d;
      meas_high_q   <= meas_high_d;
      meas_valid_q  <= meas_valid_d;
      good_run_q    <= good_run_d;
      err_q         <= err_d;
      err_count_q   <= err_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // locked is a direct decode of the registered state; it therefore changes on
  // the same edge as meas_valid, err and err_count.
  assign meas_period = meas_period_q;
  assign meas_high   = meas_high_q;
  assign meas_valid  = meas_valid_q;
  assign locked      = (state_q == ST_LOCKED);
  assign err         = err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_clk_div_checker.sv
// -----------------------------------------------------------------------------
// tb_clk_div_checker
//
// Drives div_in with hand-shaped periods. For each rising edge that should
// produce a measurement, the bench queues the expected measurement and status.
// A negedge monitor pops and compares an entry on every meas_valid pulse.
// Status that is not tied to a meas_valid pulse (reset, timeout, clear) is
// compared inline in each test task.
// -----------------------------------------------------------------------------
module tb_clk_div_checker;

  localparam int PERIOD     = 5;
  localparam int DUTY_TIME  = 1;
  localparam int CNT_W      = 8;
  localparam int LOCK_COUNT = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             div_in;
  logic             clear;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             meas_valid;
  logic             locked;
  logic             err;
  logic [7:0]       err_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             locked;
    logic             err;
    logic [7:0]       err_count;
  } meas_t;

  meas_t exp_q[$];

  clk_div_checker #(
    .PERIOD     (PERIOD),
    .DUTY_TIME  (DUTY_TIME),
    .CNT_W      (CNT_W),
    .LOCK_COUNT (LOCK_COUNT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .div_in      (div_in),
    .clear       (clear),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .err         (err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  function automatic meas_t mk(input int p, input int h, input bit l,
                               input bit e, input int c);
    meas_t m;
    m.period    = CNT_W'(p);
    m.high      = CNT_W'(h);
    m.locked    = l;
    m.err       = e;
    m.err_count = 8'(c);
    return m;
  endfunction

  // Scoreboard monitor: outputs only change at posedge or on reset, so the
  // negedge is a stable sampling point.
  always @(negedge clk) begin : monitor
    meas_t act;
    meas_t exp_v;
    if (meas_valid === 1'b1) begin
      act.period    = meas_period;
      act.high      = meas_high;
      act.locked    = locked;
      act.err       = err;
      act.err_count = err_count;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_meas_valid: got period=%0d high=%0d locked=%0b err=%0b err_count=%0d, required no pulse",
                 act.period, act.high, act.locked, act.err, act.err_count);
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          bad++;
          $display("FAIL meas @%0t: got period=%0d high=%0d locked=%0b err=%0b err_count=%0d, required period=%0d high=%0d locked=%0b err=%0b err_count=%0d",
                   $time, act.period, act.high, act.locked, act.err, act.err_count,
                   exp_v.period, exp_v.high, exp_v.locked, exp_v.err, exp_v.err_count);
        end
      end
    end
  end

  // One period of div_in: h cycles high then p-h cycles low. When push is set,
  // the measurement expected from the rising edge that starts this period
  // (which closes the previous period) is queued.
  task automatic send_period(input int p, input int h, input bit push, input meas_t e);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      if (i == 0 && push) exp_q.push_back(e);
      div_in = (i < h);
    end
  endtask

  task automatic expect_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drained: got %0d pending measurements, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Three good measurements after the first edge bring lock; locked must rise
  // exactly one clk after the 4th rising edge.
  task automatic lock_sequence(input string name);
    send_period(5, 1, 1'b0, '0);
    send_period(5, 1, 1'b1, mk(5, 1, 0, 0, 0));
    send_period(5, 1, 1'b1, mk(5, 1, 0, 0, 0));
    @(negedge clk);
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL %s_pre_lock: got locked=%0b, required 0", name, locked);
    end
    exp_q.push_back(mk(5, 1, 1, 0, 0));
    div_in = 1'b1;
    @(negedge clk);
    total++;
    if ({locked, err} !== 2'b10) begin
      bad++;
      $display("FAIL %s_lock_edge: got locked=%0b err=%0b, required locked=1 err=0", name, locked, err);
    end
    div_in = 1'b0;
    repeat (3) @(negedge clk);
    expect_drained(name);
  endtask

  task automatic test_reset();
    logic [2*CNT_W+10:0] outs;
    reset  = 1'b0;
    clear  = 1'b0;
    div_in = 1'b0;
    repeat (3) @(negedge clk);
    div_in = 1'b1;
    repeat (3) @(negedge clk);
    outs = {meas_period, meas_high, meas_valid, locked, err, err_count};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    div_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    outs = {meas_period, meas_high, meas_valid, locked, err, err_count};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_release: got %h, required 0", outs);
    end
  endtask

  task automatic test_lock();
    lock_sequence("lock");
  endtask

  task automatic test_stretch();
    send_period(6, 1, 1'b1, mk(5, 1, 1, 0, 0));
    send_period(5, 1, 1'b1, mk(6, 1, 0, 1, 1));
    send_period(5, 1, 1'b1, mk(5, 1, 0, 1, 1));
    send_period(5, 1, 1'b1, mk(5, 1, 0, 1, 1));
    send_period(5, 1, 1'b1, mk(5, 1, 1, 1, 1));
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL stretch_relock: got locked=%0b, required 1", locked);
    end
    expect_drained("stretch");
  endtask

  task automatic test_timeout();
    @(negedge clk);
    exp_q.push_back(mk(5, 1, 1, 1, 1));
    div_in = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 10) begin
        total++;
        if ({locked, err_count} !== {1'b1, 8'd1}) begin
          bad++;
          $display("FAIL timeout_early: got locked=%0b err_count=%0d, required locked=1 err_count=1", locked, err_count);
        end
      end
      if (k == 11) begin
        total++;
        if ({locked, err, err_count} !== {1'b0, 1'b1, 8'd2}) begin
          bad++;
          $display("FAIL timeout_fire: got locked=%0b err=%0b err_count=%0d, required locked=0 err=1 err_count=2", locked, err, err_count);
        end
      end
    end
    div_in = 1'b0;
    repeat (24) @(negedge clk);
    total++;
    if ({locked, err, err_count} !== {1'b0, 1'b1, 8'd2}) begin
      bad++;
      $display("FAIL timeout_single: got locked=%0b err=%0b err_count=%0d, required locked=0 err=1 err_count=2", locked, err, err_count);
    end
    expect_drained("timeout");
  endtask

  task automatic test_bad_duty();
    send_period(5, 2, 1'b0, '0);
    send_period(5, 2, 1'b1, mk(5, 2, 0, 1, 3));
    send_period(5, 2, 1'b1, mk(5, 2, 0, 1, 4));
    send_period(5, 1, 1'b1, mk(5, 2, 0, 1, 5));
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL duty_no_lock: got locked=%0b, required 0", locked);
    end
    send_period(5, 1, 1'b1, mk(5, 1, 0, 1, 5));
    send_period(5, 1, 1'b1, mk(5, 1, 0, 1, 5));
    send_period(5, 1, 1'b1, mk(5, 1, 1, 1, 5));
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL duty_relock: got locked=%0b, required 1", locked);
    end
    expect_drained("duty");
  endtask

  task automatic test_async_reset();
    logic [2*CNT_W+10:0] outs;
    total++;
    if ({locked, err_count} !== {1'b1, 8'd5}) begin
      bad++;
      $display("FAIL areset_pre: got locked=%0b err_count=%0d, required locked=1 err_count=5", locked, err_count);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    outs = {meas_period, meas_high, meas_valid, locked, err, err_count};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL areset_immediate: got %h, required 0", outs);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lock_sequence("areset");
  endtask

  task automatic test_clear();
    logic [2*CNT_W+10:0] outs;
    send_period(6, 1, 1'b1, mk(5, 1, 1, 0, 0));
    send_period(5, 1, 1'b1, mk(6, 1, 0, 1, 1));
    // Rising edge and clear in the same cycle: clear must win.
    @(negedge clk);
    div_in = 1'b1;
    clear  = 1'b1;
    @(negedge clk);
    clear  = 1'b0;
    div_in = 1'b0;
    outs = {meas_period, meas_high, meas_valid, locked, err, err_count};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL clear_with_rise: got %h, required 0", outs);
    end
    repeat (3) @(negedge clk);
    send_period(5, 1, 1'b0, '0);
    send_period(5, 1, 1'b1, mk(5, 1, 0, 0, 0));
    send_period(5, 1, 1'b1, mk(5, 1, 0, 0, 0));
    total++;
    if ({locked, err} !== 2'b00) begin
      bad++;
      $display("FAIL clear_restart: got locked=%0b err=%0b, required locked=0 err=0", locked, err);
    end
    expect_drained("clear");
  endtask

  task automatic test_saturation();
    send_period(5, 2, 1'b1, mk(5, 1, 1, 0, 0));
    for (int i = 1; i <= 258; i++) begin
      send_period(5, 2, 1'b1, mk(5, 2, 0, 1, (i > 255) ? 255 : i));
    end
    total++;
    if ({err, err_count} !== {1'b1, 8'd255}) begin
      bad++;
      $display("FAIL err_count_saturate: got err=%0b err_count=%0d, required err=1 err_count=255", err, err_count);
    end
    expect_drained("saturation");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_stretch();
    test_timeout();
    test_bad_duty();
    test_async_reset();
    test_clear();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
